// File: rtl/fir_tap_feeder.sv
// fir_tap_feeder: FIR front end. Accepts samples over valid/ready, shifts them
// into a NUM_TAPS-deep delay line, and registers one signed product per tap
// for the pipelined adder tree. It also tracks sample validity through the
// tree latency.
// Optional build macro FIR_FEEDER_COEF_READBACK_EN adds a registered
// coefficient readback port (coef_raddr / coef_rdata).
module fir_tap_feeder #(
    parameter int DATA_WIDTH   = 16,
    parameter int COEF_WIDTH   = 16,
    parameter int NUM_TAPS     = 53,
    parameter int TREE_LATENCY = $clog2(NUM_TAPS)
) (
    input  logic                                               clk,
    input  logic                                               resetn,
    input  logic                                               in_valid,
    output logic                                               in_ready,
    input  logic [DATA_WIDTH-1:0]                              in_data,
    input  logic                                               flush,
    input  logic                                               coef_we,
    input  logic [$clog2(NUM_TAPS)-1:0]                        coef_addr,
    input  logic [COEF_WIDTH-1:0]                              coef_wdata,
    output logic [NUM_TAPS-1:0][DATA_WIDTH+COEF_WIDTH-1:0]     prod,
    output logic                                               prod_valid,
    output logic                                               sum_valid,
    output logic                                               primed
`ifdef FIR_FEEDER_COEF_READBACK_EN
    ,
    input  logic [$clog2(NUM_TAPS)-1:0]                        coef_raddr,
    output logic [COEF_WIDTH-1:0]                              coef_rdata
`endif
);

    localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;
    localparam int ADDR_WIDTH = $clog2(NUM_TAPS);
    localparam int CNT_WIDTH  = $clog2(NUM_TAPS + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_TAPS - 1);
    localparam logic [CNT_WIDTH-1:0]  FULL_CNT  = CNT_WIDTH'(NUM_TAPS);

    logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] tap_q, tap_d;
    logic [NUM_TAPS-1:0][COEF_WIDTH-1:0] coef_q, coef_d;
    logic [NUM_TAPS-1:0][PROD_WIDTH-1:0] prod_q, prod_d;
    logic [CNT_WIDTH-1:0]                fill_q, fill_d;
    logic                                prod_valid_q, prod_valid_d;
    logic [TREE_LATENCY-1:0]             sum_pipe_q, sum_pipe_d;

    logic                                accept;
    logic signed [DATA_WIDTH-1:0]        mul_a;
    logic signed [COEF_WIDTH-1:0]        mul_b;
    logic signed [PROD_WIDTH-1:0]        mul_p;

    assign in_ready = !flush;
    assign accept   = in_valid & in_ready;

    // Delay line shift on accept, clear on flush; fill count saturates at NUM_TAPS.
    always_comb begin
        tap_d  = tap_q;
        fill_d = fill_q;
        if (flush) begin
            tap_d  = '0;
            fill_d = '0;
        end else if (accept) begin
            tap_d[0] = in_data;
            for (int unsigned k = 1; k < NUM_TAPS; k++) begin
                tap_d[k] = tap_q[k-1];
            end
            if (fill_q != FULL_CNT) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // Products use the shifted taps and the coefficients held before this edge,
    // so a write landing on the same edge only affects later samples.
    always_comb begin
        prod_d = prod_q;
        mul_a  = '0;
        mul_b  = '0;
        mul_p  = '0;
        if (accept) begin
            for (int unsigned k = 0; k < NUM_TAPS; k++) begin
                mul_a     = tap_d[k];
                mul_b     = coef_q[k];
                mul_p     = mul_a * mul_b;
                prod_d[k] = mul_p;
            end
        end
    end

    // Coefficient write; out-of-range addresses are dropped.
    always_comb begin
        coef_d = coef_q;
        if (coef_we && (coef_addr <= LAST_ADDR)) begin
            coef_d[coef_addr] = coef_wdata;
        end
    end

    // Validity pipeline: product valid one cycle after accept, then tree latency.
    always_comb begin
        prod_valid_d  = accept;
        sum_pipe_d    = sum_pipe_q;
        sum_pipe_d[0] = prod_valid_q;
        for (int unsigned i = 1; i < TREE_LATENCY; i++) begin
            sum_pipe_d[i] = sum_pipe_q[i-1];
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tap_q        <= '0;
            coef_q       <= '0;
            prod_q       <= '0;
            fill_q       <= '0;
            prod_valid_q <= 1'b0;
            sum_pipe_q   <= '0;
        end else begin
            tap_q        <= tap_d;
            coef_q       <= coef_d;
            prod_q       <= prod_d;
            fill_q       <= fill_d;
            prod_valid_q <= prod_valid_d;
            sum_pipe_q   <= sum_pipe_d;
        end
    end

    assign prod       = prod_q;
    assign prod_valid = prod_valid_q;
    assign sum_valid  = sum_pipe_q[TREE_LATENCY-1];
    assign primed     = (fill_q == FULL_CNT);

`ifdef FIR_FEEDER_COEF_READBACK_EN
    logic [COEF_WIDTH-1:0] coef_rdata_q, coef_rdata_d;

    // Registered readback of the pre-edge coefficient; out-of-range reads return 0.
    always_comb begin
        coef_rdata_d = '0;
        if (coef_raddr <= LAST_ADDR) begin
            coef_rdata_d = coef_q[coef_raddr];
        end
    end

    // Readback register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            coef_rdata_q <= '0;
        end else begin
            coef_rdata_q <= coef_rdata_d;
        end
    end

    assign coef_rdata = coef_rdata_q;
`endif

endmodule

// File: tb/tb_fir_tap_feeder.sv
// Scoreboard bench for fir_tap_feeder: a stimulus process updates a reference
// model and queues expected product vectors; a negedge monitor checks outputs.
module tb_fir_tap_feeder;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int NT = 53;
    localparam int TL = $clog2(NT);
    localparam int PW = DW + CW;
    localparam int AW = $clog2(NT);

    typedef logic [NT-1:0][PW-1:0] pvec_t;

    logic            clk = 1'b0;
    logic            resetn;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            flush;
    logic            coef_we;
    logic [AW-1:0]   coef_addr;
    logic [CW-1:0]   coef_wdata;
    pvec_t           prod;
    logic            prod_valid;
    logic            sum_valid;
    logic            primed;

    fir_tap_feeder #(
        .DATA_WIDTH (DW),
        .COEF_WIDTH (CW),
        .NUM_TAPS   (NT)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .flush      (flush),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .prod       (prod),
        .prod_valid (prod_valid),
        .sum_valid  (sum_valid),
        .primed     (primed)
    );

    always #5 clk = ~clk;

    int    vectors = 0;
    int    miscompares = 0;
    int    m_tap [NT];
    int    m_coef[NT];
    int    m_fill;
    int    cyc;
    bit    acc_edge [0:16383];
    pvec_t exp_q[$];
    bit    mon_on = 1'b0;
    bit    done = 1'b0;

    function automatic int rnd16();
        logic signed [15:0] r;
        r = 16'($urandom);
        return int'(r);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NT; k++) begin
            m_tap[k]  = 0;
            m_coef[k] = 0;
        end
        m_fill = 0;
        exp_q.delete();
        for (int i = 0; i < 16384; i++) acc_edge[i] = 1'b0;
    endtask

    // Apply one cycle of inputs, then advance the model across that clock edge.
    task automatic step(input bit v, input int d, input bit f,
                        input bit we, input int a, input int wd);
        pvec_t pv;
        in_valid   = v;
        in_data    = DW'(d);
        flush      = f;
        coef_we    = we;
        coef_addr  = AW'(a);
        coef_wdata = CW'(wd);
        @(posedge clk);
        cyc++;
        if (resetn) begin
            if (f) begin
                for (int k = 0; k < NT; k++) m_tap[k] = 0;
                m_fill = 0;
            end else if (v) begin
                for (int k = NT - 1; k > 0; k--) m_tap[k] = m_tap[k-1];
                m_tap[0] = d;
                if (m_fill < NT) m_fill++;
                for (int k = 0; k < NT; k++) pv[k] = PW'(m_tap[k] * m_coef[k]);
                exp_q.push_back(pv);
                acc_edge[cyc] = 1'b1;
            end
            if (we && a < NT) m_coef[a] = wd;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset asserted away from the clock edge, outputs checked at once.
    task automatic do_reset();
        in_valid = 0; flush = 0; coef_we = 0;
        resetn = 1'b0;
        model_clear();
        #1;
        check("rst_prod", longint'(prod != '0), 0);
        check("rst_prod_valid", prod_valid, 0);
        check("rst_sum_valid", sum_valid, 0);
        check("rst_primed", primed, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        resetn = 1'b1;
    endtask

    // Monitor: per-cycle control checks and scoreboard pop on prod_valid.
    initial begin
        pvec_t ev;
        while (!done) begin
            @(negedge clk);
            if (mon_on && resetn) begin
                check("in_ready", in_ready, !flush);
                check("prod_valid", prod_valid, acc_edge[cyc]);
                check("sum_valid", sum_valid, (cyc >= TL) ? acc_edge[cyc-TL] : 1'b0);
                check("primed", primed, (m_fill == NT) ? 1 : 0);
                if (prod_valid) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL prod_unexpected: prod_valid high with no queued expectation (edge %0d)", cyc);
                    end else begin
                        ev = exp_q.pop_front();
                        if (prod !== ev) begin
                            miscompares++;
                            for (int k = 0; k < NT; k++) begin
                                if (prod[k] !== ev[k]) begin
                                    $display("FAIL prod_vec: tap %0d got %0d expected %0d (edge %0d)",
                                             k, $signed(prod[k]), $signed(ev[k]), cyc);
                                    break;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        in_valid = 0; in_data = '0; flush = 0; coef_we = 0; coef_addr = '0; coef_wdata = '0;
        cyc = 0;
        resetn = 1'b1;
        #2;
        do_reset();
        mon_on = 1'b1;
        idle(2);

        // Impulse response with coef[k] = k+1.
        for (int k = 0; k < NT; k++) step(0, 0, 0, 1, k, k + 1);
        for (int m = 1; m <= NT; m++) begin
            step(1, (m == 1) ? 1 : 0, 0, 0, 0, 0);
            check("impulse_tap", $signed(prod[m-1]), m);
        end
        check("impulse_primed", primed, 1);

        // Single-sample validity timing.
        idle(10);
        step(1, 3, 0, 0, 0, 0);
        idle(10);

        // Extreme operands.
        for (int k = 0; k < NT; k++) step(0, 0, 0, 1, k, -32768);
        for (int m = 0; m < NT; m++) step(1, -32768, 0, 0, 0, 0);
        check("extreme_primed", primed, 1);
        check("extreme_prod0", $signed(prod[0]), 1073741824);
        check("extreme_prod52", $signed(prod[NT-1]), 1073741824);

        // Flush with a concurrent valid: sample dropped, line cleared.
        in_valid = 1; flush = 1; #1;
        check("flush_in_ready", in_ready, 0);
        step(1, 1234, 1, 0, 0, 0);
        check("flush_primed", primed, 0);
        step(1, 7, 0, 0, 0, 0);
        check("flush_prod1", $signed(prod[1]), 0);
        check("flush_prod0", $signed(prod[0]), -229376);

        // Coefficient update ordering and out-of-range write.
        step(0, 0, 0, 1, 0, 2);
        step(1, 5, 0, 0, 0, 0);
        check("coef_old", $signed(prod[0]), 10);
        step(1, 5, 0, 1, 0, 3);
        check("coef_same_cycle", $signed(prod[0]), 10);
        step(1, 5, 0, 0, 0, 0);
        check("coef_new", $signed(prod[0]), 15);
        step(0, 0, 0, 1, 60, 99);
        step(1, 5, 0, 0, 0, 0);
        check("coef_oob", $signed(prod[0]), 15);

        // Randomized traffic with a reset in the middle.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                do_reset();
                check("midrst_prod", longint'(prod != '0), 0);
            end
            step($urandom_range(0, 9) < 7, rnd16(), $urandom_range(0, 19) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 63), rnd16());
        end

        idle(TL + 4);
        check("scoreboard_empty", exp_q.size(), 0);

        done = 1'b1;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
